regfile: RTL and testbench

//  - MIPS general-purpose register file: 32 registers of WIDTH bits, two combinational read ports (rs, rt) and one synchronous write port (rd).
//  - Sits between decode and execute in the single-cycle mips_core.
//  - The register index is always the raw 5-bit instruction field or the I/R-type write-address mux output.
//  - Register $0 reads as constant zero.
//  - The core's halted flag freezes the file; optionally it also triggers a full register dump.

---
 rtl/regfile.sv | 46 ++++
 tb/tb_regfile.sv | 100 ++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: MIPS 32 x WIDTH register file, two combinational read ports, one write port, $0 hard-wired to zero.
// Optional REGFILE_DUMP_EN (simulation only) prints all registers once per halt episode.
module regfile #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [4:0]       rs_num,
  input  logic [4:0]       rt_num,
  input  logic [4:0]       rd_num,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             rd_we,
  input  logic             halted,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data
);
  logic [WIDTH-1:0] regs [0:31];
  logic             wr_en;
  assign wr_en = rd_we && !halted && (rd_num != 5'd0);
  // Storage: async clear, write gated by enable, halt and $0 protection
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd_num] <= rd_data;
    end
  end
  // Read ports: no bypass, index 0 forced to zero
  always_comb begin
    rs_data = (rs_num == 5'd0) ? '0 : regs[rs_num];
    rt_data = (rt_num == 5'd0) ? '0 : regs[rt_num];
  end
`ifdef REGFILE_DUMP_EN
  logic halted_q;
  // Dump once on the rising edge of halted; re-armed when halted drops or on reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      halted_q <= 1'b0;
    end else begin
      if (halted && !halted_q)
        for (int i = 0; i < 32; i++) $display("R%0d = 0x%08h", i, regs[i]);
      halted_q <= halted;
    end
  end
`endif
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
module tb_regfile;
  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic [4:0]  rs_num = '0, rt_num = '0, rd_num = '0;
  logic [31:0] rd_data = '0;
  logic        rd_we = 1'b0, halted = 1'b0;
  logic [31:0] rs_data, rt_data;
  int          checks = 0, errors = 0;

  regfile #(.WIDTH(32)) dut (
    .clk(clk), .rst_b(rst_b), .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num),
    .rd_data(rd_data), .rd_we(rd_we), .halted(halted), .rs_data(rs_data), .rt_data(rt_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [4:0] n, input logic [31:0] d);
    @(negedge clk);
    rd_we = 1'b1; rd_num = n; rd_data = d;
    @(posedge clk); #1;
    rd_we = 1'b0;
  endtask

  initial begin
    wr(5'd5, 32'h11);
    wr(5'd31, 32'h22);
    rs_num = 5'd5; rt_num = 5'd31; #1;
    chk("pre_r5", rs_data, 32'h11);
    chk("pre_r31", rt_data, 32'h22);
    @(negedge clk); #1;
    rst_b = 1'b0; #1;
    chk("rst_rs5", rs_data, 32'h0);
    chk("rst_rt31", rt_data, 32'h0);
    rst_b = 1'b1; #1;
    chk("rst_rel_rs5", rs_data, 32'h0);

    @(negedge clk);
    rd_we = 1'b1; rd_num = 5'd8; rd_data = 32'h2A; rs_num = 5'd8; #1;
    chk("r8_before", rs_data, 32'h0);
    @(posedge clk); #1;
    rd_we = 1'b0;
    chk("r8_after", rs_data, 32'h2A);

    wr(5'd0, 32'hFFFF_FFFF);
    rs_num = 5'd0; rt_num = 5'd0; #1;
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_rt", rt_data, 32'h0);

    wr(5'd9, 32'h1234_5678);
    wr(5'd10, 32'hDEAD_BEEF);
    rs_num = 5'd9; rt_num = 5'd10; #1;
    chk("dual_rs9", rs_data, 32'h1234_5678);
    chk("dual_rt10", rt_data, 32'hDEAD_BEEF);
    rs_num = 5'd10; #1;
    chk("same_rs10", rs_data, 32'hDEAD_BEEF);
    chk("same_rt10", rt_data, 32'hDEAD_BEEF);

    @(negedge clk);
    halted = 1'b1; rd_we = 1'b1; rd_num = 5'd8; rd_data = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    rd_num = 5'd11;
    @(posedge clk); #1;
    rd_we = 1'b0;
    rs_num = 5'd8; rt_num = 5'd11; #1;
    chk("halt_r8", rs_data, 32'h2A);
    chk("halt_r11", rt_data, 32'h0);
    @(negedge clk);
    halted = 1'b0;
    wr(5'd11, 32'hA5A5_0001);
    #1;
    chk("unhalt_r11", rt_data, 32'hA5A5_0001);

    @(negedge clk);
    rd_we = 1'b1; rd_num = 5'd8; rd_data = 32'h77; rs_num = 5'd8; rt_num = 5'd9;
    rst_b = 1'b0; #1;
    chk("mid_rst_r8", rs_data, 32'h0);
    chk("mid_rst_r9", rt_data, 32'h0);
    @(posedge clk); #1;
    chk("rst_over_wr", rs_data, 32'h0);
    @(negedge clk);
    rd_we = 1'b0; rst_b = 1'b1;
    wr(5'd8, 32'h99);
    #1;
    chk("post_rst_wr", rs_data, 32'h99);
    chk("post_rst_r9", rt_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
